// File: rtl/normal_clt_accum_if.sv
// Bundles the multiplier-side and consumer-side signals of the CLT accumulator.
//
// Handshake rules for both valid/ready pairs:
//   A transfer happens on a rising clock edge where valid and ready are both 1.
//   The producer holds valid and its data steady until that transfer.
//   The consumer may raise or drop ready in any cycle.
//   src_ready equals mul_ce, so an operand is captured exactly when the multiplier advances.
interface normal_clt_accum_if #(
   parameter int IN_WIDTH  = 24,
   parameter int OUT_WIDTH = 28
);
   logic                 src_valid;
   logic                 src_ready;
   logic                 mul_ce;
   logic [IN_WIDTH-1:0]  mul_dout;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;

   // Accumulator side.
   modport master (
      input  src_valid,
      output src_ready,
      output mul_ce,
      input  mul_dout,
      output out_valid,
      input  out_ready,
      output out_data
   );

   // Environment side: the upstream source, the multiplier and the consumer.
   modport slave (
      output src_valid,
      input  src_ready,
      input  mul_ce,
      output mul_dout,
      input  out_valid,
      output out_ready,
      input  out_data
   );
endinterface

// File: rtl/normal_clt_accum.sv
// Central-limit-theorem accumulator placed after the scaling multiplier.
// The block owns the multiplier clock-enable and tracks tokens in flight with vpipe.
// Each group of SUM_COUNT signed products becomes one output sample.
// The multiplier freezes only when the tail holds a group's last product and the
// output register is still occupied. All other products are absorbed freely.
module normal_clt_accum #(
   parameter int MUL_LATENCY = 4,
   parameter int IN_WIDTH    = 24,
   parameter int SUM_COUNT   = 12,
   parameter int CNT_WIDTH   = 4,
   parameter int OUT_WIDTH   = 28
) (
   input  logic                clk,
   input  logic                reset,
   normal_clt_accum_if.master  bus
);

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(SUM_COUNT - 1);

   logic [MUL_LATENCY-1:0] vpipe;
   logic [CNT_WIDTH-1:0]   cnt;
   logic [OUT_WIDTH-1:0]   acc;
   logic [OUT_WIDTH-1:0]   out_data_q;
   logic                   out_valid_q;

   logic                   tail;
   logic                   last;
   logic                   block;
   logic                   stall;
   logic                   ce;
   logic                   absorb;
   logic [OUT_WIDTH-1:0]   product;

   // Stall decision. It is combinational from out_ready so the freeze starts in the same cycle.
   always_comb begin
      tail    = vpipe[MUL_LATENCY-1];
      last    = (cnt == LAST_CNT);
      block   = last & out_valid_q & ~bus.out_ready;
      stall   = tail & block;
      ce      = ~stall & ~reset;
      absorb  = tail & ce;
      product = OUT_WIDTH'($signed(bus.mul_dout));
   end

   assign bus.mul_ce    = ce;
   assign bus.src_ready = ce;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   // Token tracking, group accumulation and the output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         vpipe       <= '0;
         cnt         <= '0;
         acc         <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         // vpipe advances in lockstep with the multiplier pipeline.
         if (ce) begin
            vpipe[0] <= bus.src_valid & ce;
            for (int i = 1; i < MUL_LATENCY; i++) begin
               vpipe[i] <= vpipe[i-1];
            end
         end

         if (absorb && !last) begin
            acc <= acc + product;
            cnt <= cnt + CNT_WIDTH'(1);
         end else if (absorb && last) begin
            // A load takes priority over a handshake in the same cycle.
            // out_valid stays 1, so throughput is not lost.
            out_data_q  <= acc + product;
            out_valid_q <= 1'b1;
            acc         <= '0;
            cnt         <= '0;
         end

         if (!(absorb && last) && out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_normal_clt_accum.sv
// Bench for normal_clt_accum with a four-stage multiplier model that honours mul_ce.
// Accepted tokens are grouped into expected sums, and every output handshake is
// matched in order against the expected queue.
module tb_normal_clt_accum;

   localparam int MUL_LATENCY = 4;
   localparam int IN_WIDTH    = 24;
   localparam int SUM_COUNT   = 12;
   localparam int CNT_WIDTH   = 4;
   localparam int OUT_WIDTH   = 28;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   // clock
   always #5 clk = ~clk;

   normal_clt_accum_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

   normal_clt_accum #(
      .MUL_LATENCY (MUL_LATENCY),
      .IN_WIDTH    (IN_WIDTH),
      .SUM_COUNT   (SUM_COUNT),
      .CNT_WIDTH   (CNT_WIDTH),
      .OUT_WIDTH   (OUT_WIDTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Multiplier model: product presented at its input travels MUL_LATENCY ce-cycles.
   logic [IN_WIDTH-1:0] p_in;
   logic [IN_WIDTH-1:0] mpipe [MUL_LATENCY];

   initial begin
      for (int i = 0; i < MUL_LATENCY; i++) mpipe[i] = '0;
   end

   always @(posedge clk) begin
      if (bus.mul_ce) begin
         mpipe[0] <= p_in;
         for (int i = 1; i < MUL_LATENCY; i++) mpipe[i] <= mpipe[i-1];
      end
   end

   assign bus.mul_dout = mpipe[MUL_LATENCY-1];

   // scoreboard and reference model state
   logic [OUT_WIDTH-1:0] exp_q[$];
   longint               grp_sum;
   int                   grp_n;
   int                   ntok;
   int                   nout;
   logic [OUT_WIDTH-1:0] last_out;
   int                   tests = 0;
   int                   fails = 0;

   logic                 s_valid;
   logic [OUT_WIDTH-1:0] s_data;
   logic                 s_ce;
   logic                 s_ready;

   initial begin
      bus.src_valid = 1'b0;
      bus.out_ready = 1'b0;
      p_in          = '0;
      grp_sum       = 0;
      grp_n         = 0;
   end

   // One clock cycle. Inputs are driven at the negedge and sampled 1 time unit later.
   task automatic step(input logic v, input logic [IN_WIDTH-1:0] p, input logic rdy);
      logic [OUT_WIDTH-1:0] e;
      @(negedge clk);
      bus.src_valid = v;
      p_in          = p;
      bus.out_ready = rdy;
      #1;
      s_valid = bus.out_valid;
      s_data  = bus.out_data;
      s_ce    = bus.mul_ce;
      s_ready = bus.src_ready;
      if (v && bus.src_ready) begin
         ntok++;
         grp_sum += longint'($signed(p));
         grp_n++;
         if (grp_n == SUM_COUNT) begin
            exp_q.push_back(OUT_WIDTH'(grp_sum));
            grp_sum = 0;
            grp_n   = 0;
         end
      end
      if (bus.out_valid && rdy) begin
         nout++;
         last_out = bus.out_data;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_extra: got %0d, required no output", $signed(bus.out_data));
         end else begin
            e = exp_q.pop_front();
            if (bus.out_data !== e) begin
               fails++;
               $display("FAIL scoreboard_sum: got %0d, required %0d", $signed(bus.out_data), $signed(e));
            end
         end
      end
   endtask

   // Apply reset for one cycle. Discard all model state, because nothing survives reset.
   task automatic do_reset();
      @(negedge clk);
      bus.src_valid = 1'b0;
      bus.out_ready = 1'b0;
      reset         = 1'b1;
      #1;
      tests++;
      if (bus.src_ready !== 1'b0 || bus.mul_ce !== 1'b0) begin
         fails++;
         $display("FAIL reset_ce_low: got src_ready=%b mul_ce=%b, required 0 0", bus.src_ready, bus.mul_ce);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
         fails++;
         $display("FAIL reset_out: got valid=%b data=%0d, required 0 0", bus.out_valid, bus.out_data);
      end
      tests++;
      if (bus.src_ready !== 1'b1 || bus.mul_ce !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_ce: got src_ready=%b mul_ce=%b, required 1 1", bus.src_ready, bus.mul_ce);
      end
      exp_q.delete();
      grp_sum = 0;
      grp_n   = 0;
      ntok    = 0;
      nout    = 0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, IN_WIDTH'($urandom), 1'b1);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain_empty: got %0d pending sums, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      do_reset();
   endtask

   task automatic test_basic();
      int first_t;
      int pulses;
      logic [OUT_WIDTH-1:0] first_d;
      do_reset();
      first_t = -1;
      pulses  = 0;
      first_d = '0;
      for (int t = 0; t < 30; t++) begin
         step(t < 12, IN_WIDTH'(1000), 1'b1);
         if (s_valid) begin
            pulses++;
            if (first_t < 0) begin
               first_t = t;
               first_d = s_data;
            end
         end
      end
      tests++;
      if (first_t != 16) begin
         fails++;
         $display("FAIL basic_latency: got cycle %0d, required 16", first_t);
      end
      tests++;
      if (first_d !== OUT_WIDTH'(12000)) begin
         fails++;
         $display("FAIL basic_sum: got %0d, required 12000", $signed(first_d));
      end
      tests++;
      if (pulses != 1) begin
         fails++;
         $display("FAIL basic_pulses: got %0d, required 1", pulses);
      end
      drain(4);
   endtask

   task automatic test_extremes();
      logic [OUT_WIDTH-1:0] req;
      do_reset();
      for (int t = 0; t < 12; t++) step(1'b1, 24'h800000, 1'b1);
      drain(10);
      req = OUT_WIDTH'(-100663296);
      tests++;
      if (nout != 1 || last_out !== req) begin
         fails++;
         $display("FAIL extreme_neg: got %0d (n=%0d), required %0d (n=1)", $signed(last_out), nout, $signed(req));
      end
      nout = 0;
      for (int t = 0; t < 12; t++) step(1'b1, 24'h7FFFFF, 1'b1);
      drain(10);
      req = OUT_WIDTH'(100663284);
      tests++;
      if (nout != 1 || last_out !== req) begin
         fails++;
         $display("FAIL extreme_pos: got %0d (n=%0d), required %0d (n=1)", $signed(last_out), nout, $signed(req));
      end
   endtask

   task automatic test_backpressure();
      int first_stall;
      do_reset();
      first_stall = -1;
      for (int t = 0; t < 32; t++) begin
         step(ntok < 24, IN_WIDTH'(ntok + 1), 1'b0);
         if (!s_ce && first_stall < 0) first_stall = t;
      end
      tests++;
      if (first_stall != 27) begin
         fails++;
         $display("FAIL bp_stall_cycle: got %0d, required 27", first_stall);
      end
      tests++;
      if (ntok != 24) begin
         fails++;
         $display("FAIL bp_tokens: got %0d, required 24", ntok);
      end
      tests++;
      if (s_valid !== 1'b1 || s_data !== OUT_WIDTH'(78) || s_ce !== 1'b0 || s_ready !== 1'b0) begin
         fails++;
         $display("FAIL bp_hold: got valid=%b data=%0d ce=%b ready=%b, required 1 78 0 0", s_valid, $signed(s_data), s_ce, s_ready);
      end
      step(1'b0, '0, 1'b1);
      tests++;
      if (s_ce !== 1'b1) begin
         fails++;
         $display("FAIL bp_release_ce: got %b, required 1", s_ce);
      end
      step(1'b0, '0, 1'b0);
      tests++;
      if (s_valid !== 1'b1 || s_data !== OUT_WIDTH'(222)) begin
         fails++;
         $display("FAIL bp_second: got valid=%b data=%0d, required 1 222", s_valid, $signed(s_data));
      end
      drain(4);
      tests++;
      if (nout != 2 || ntok != 24) begin
         fails++;
         $display("FAIL bp_totals: got outputs=%0d tokens=%0d, required 2 24", nout, ntok);
      end
   endtask

   task automatic test_bubbles();
      int t;
      do_reset();
      t = 0;
      while (ntok < 36 && t < 500) begin
         step(1'($urandom_range(0, 1)), IN_WIDTH'($urandom), 1'b1);
         t++;
      end
      tests++;
      if (ntok != 36) begin
         fails++;
         $display("FAIL bubbles_budget: got %0d tokens, required 36", ntok);
      end
      drain(12);
      tests++;
      if (nout != 3) begin
         fails++;
         $display("FAIL bubbles_count: got %0d sums, required 3", nout);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int t = 0; t < 5; t++) step(1'b1, IN_WIDTH'(7), 1'b1);
      do_reset();
      for (int t = 0; t < 12; t++) step(1'b1, IN_WIDTH'(3), 1'b1);
      drain(12);
      tests++;
      if (nout != 1 || last_out !== OUT_WIDTH'(36)) begin
         fails++;
         $display("FAIL reset_mid: got %0d (n=%0d), required 36 (n=1)", $signed(last_out), nout);
      end
   endtask

   task automatic test_back_to_back();
      longint sum2;
      logic [IN_WIDTH-1:0] p;
      int stalls;
      logic v28, v29;
      logic [OUT_WIDTH-1:0] d28;
      do_reset();
      sum2   = 0;
      stalls = 0;
      v28 = 1'b0; v29 = 1'b1; d28 = '0;
      for (int t = 0; t < 34; t++) begin
         p = IN_WIDTH'($urandom);
         if (t >= 12 && t < 24) sum2 += longint'($signed(p));
         step(t < 24, p, t >= 27);
         if (!s_ce) stalls++;
         if (t == 28) begin
            v28 = s_valid;
            d28 = s_data;
         end
         if (t == 29) v29 = s_valid;
      end
      tests++;
      if (v28 !== 1'b1 || d28 !== OUT_WIDTH'(sum2)) begin
         fails++;
         $display("FAIL b2b_load: got valid=%b data=%0d, required 1 %0d", v28, $signed(d28), sum2);
      end
      tests++;
      if (v29 !== 1'b0) begin
         fails++;
         $display("FAIL b2b_drop: got valid=%b, required 0", v29);
      end
      tests++;
      if (stalls != 0 || nout != 2) begin
         fails++;
         $display("FAIL b2b_flow: got stalls=%0d outputs=%0d, required 0 2", stalls, nout);
      end
      drain(2);
   endtask

   task automatic test_random();
      int t;
      do_reset();
      t = 0;
      while (ntok < 60 && t < 3000) begin
         step($urandom_range(0, 9) < 6, IN_WIDTH'($urandom), $urandom_range(0, 1) == 1);
         t++;
      end
      tests++;
      if (ntok != 60) begin
         fails++;
         $display("FAIL random_budget: got %0d tokens, required 60", ntok);
      end
      drain(30);
      tests++;
      if (nout != 5) begin
         fails++;
         $display("FAIL random_count: got %0d sums, required 5", nout);
      end
   endtask

   // test sequence and final report
   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_backpressure();
      test_bubbles();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/normal_clt_accum.md
# normal_clt_accum

Central-limit-theorem accumulator that sits directly downstream of the 16s×9ns→24-bit, 4-stage scaling multiplier in the normal RNG datapath. It owns the multiplier's clock-enable, tracks tokens in flight through the multiplier pipeline, and sums each group of SUM_COUNT signed scaled uniforms into one approximately Gaussian sample. Results leave through a valid/ready interface toward the channel-model consumer.

## Interface
- MUL_LATENCY, 4: multiplier pipeline depth in ce-qualified cycles.
- IN_WIDTH, 24: multiplier product width, signed.
- SUM_COUNT, 12: products summed per output sample; legal range 2..16.
- CNT_WIDTH, 4: group counter width; must satisfy 2^CNT_WIDTH ≥ SUM_COUNT.
- OUT_WIDTH, 28: sum width; must equal IN_WIDTH + CNT_WIDTH.

- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- src_valid  in  1  upstream operands present on the multiplier din0/din1.
- src_ready  out  1  operands are captured by the multiplier this cycle.
- mul_ce  out  1  clock-enable driven to the multiplier ce.
- mul_dout  in  IN_WIDTH  multiplier dout, signed.
- out_valid  out  1  out_data holds a completed sum.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  OUT_WIDTH  signed sum of SUM_COUNT products.

## Operation
- vpipe[MUL_LATENCY-1:0] is a token shift register. On every cycle with mul_ce=1: vpipe[0] ← src_valid & src_ready, and vpipe[i] ← vpipe[i-1]. With mul_ce=0 it holds, matching the multiplier, which also freezes.
- tail = vpipe[MUL_LATENCY-1]. When tail=1, mul_dout is a valid product.
- block = (cnt == SUM_COUNT-1) & out_valid & ~out_ready.
- stall = tail & block.
- mul_ce = ~stall & ~reset.
- src_ready = mul_ce.
- Absorb event = tail & mul_ce. The product is sign-extended to OUT_WIDTH.
  - If cnt < SUM_COUNT-1: acc ← acc + product, cnt ← cnt+1.
  - If cnt = SUM_COUNT-1: out_data ← acc + product, out_valid ← 1, acc ← 0, cnt ← 0.
- Output handshake: out_valid & out_ready with no load in the same cycle → out_valid ← 0, out_data holds its value. A load in the same cycle as a handshake → out_valid stays 1 and out_data takes the new sum. This keeps full throughput.
- Bubbles (src_valid=0 while mul_ce=1) move through vpipe as zeros. They never count toward a group.
- The sum cannot overflow: |sum| ≤ SUM_COUNT·2^(IN_WIDTH-1) ≤ 2^(OUT_WIDTH-1).
- No data is lost or duplicated under any pattern of src_valid and out_ready.

## Timing
- Reset values: out_valid=0, out_data=0, acc=0, cnt=0, vpipe=0. src_ready=0 and mul_ce=0 while reset=1. Both are 1 in the first cycle after reset.
- Products in flight when reset is asserted are discarded through vpipe clear. The multiplier's unreset registers are don't-care.
- Reset mid-group drops the partial sum. The next accepted token starts a fresh group.
- Latency with no backpressure: a token accepted in cycle k has tail=1 in cycle k+MUL_LATENCY and is absorbed at the end of that cycle. If it is the last token of a group, out_valid=1 from cycle k+MUL_LATENCY+1.
- Throughput: one token per cycle and one sum per SUM_COUNT cycles when out_ready=1.
- Backpressure: stall is combinational from out_ready. mul_ce and src_ready fall in the same cycle that out_ready=0 meets a pending last product. They rise in the cycle out_ready returns to 1.
- Stall only occurs when the tail holds a group's last product and the output register is still occupied. All other products absorb freely.

## Test plan
- Basic sum: after reset, 12 back-to-back tokens in cycles 0–11 with mul_dout=1000 each, out_ready=1 → out_valid first high in cycle 16, out_data=12000, one cycle wide. No other out_valid pulse.
- Extreme negative: 12 products of -8388608 → out_data=-100663296 (0xA000000 in 28 bits), no wrap. Repeat with +8388607 ×12 → 100663284.
- Backpressure: out_ready=0, src_valid=1 continuous for 24 tokens with products 1..24 →
  - First sum 78 is held.
  - mul_ce and src_ready drop when token 24 reaches the tail.
  - Raising out_ready for 1 cycle → 78 accepted, then 222 presented.
  - Exactly 24 tokens are accepted in total.
- Bubbles: src_valid random at 50% for 36 accepted tokens with known products → exactly 3 sums, each equal to the reference model's group sum.
- Reset mid-group: 5 tokens of value 7, then reset for 1 cycle, then 12 tokens of value 3 → a single output of 36; the 7s never appear.
- Simultaneous handshake and load: out_valid=1 with out_ready=1 in the cycle the next group's 12th product is absorbed → out_valid stays high and out_data changes to the new sum next cycle. No gap, no duplicate.
